// File: rtl/pipe_control.sv
// Control path of a five-stage MIPS-style pipeline: decode, control pipeline
// registers (ID/EX, EX/MEM, MEM/WB), forwarding selects and hazard logic.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   opD, functD       opcode / funct of the instruction in Decode
//   rsD, rtD, rdD     register fields in Decode
//   rsE, rtE          source registers in Execute (from datapath ID/EX)
//   eqD               Decode-stage register equality result
//   flush             external Execute flush request
//   regWriteW, mem2RegW      Writeback controls
//   memWriteM                Memory store enable
//   regDst, aluSrcB, aluControl  Execute controls
//   pcSrc             branch taken (combinational, Decode)
//   fad, fbd          Execute operand A/B forward selects
//   stallF, stallD, flushE, flushD  hazard controls
module pipe_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opD,
    input  logic [5:0] functD,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rdD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic       eqD,
    input  logic       flush,
    output logic       regWriteW,
    output logic       mem2RegW,
    output logic       memWriteM,
    output logic       regDst,
    output logic       aluSrcB,
    output logic [2:0] aluControl,
    output logic       pcSrc,
    output logic [1:0] fad,
    output logic [1:0] fbd,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE,
    output logic       flushD
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       regWriteD;
    logic       regDstD;
    logic       aluSrcBD;
    logic       branchD;
    logic       memWriteD;
    logic       mem2RegD;
    logic [2:0] aluCtrlD;

    logic isR;
    logic isLw;
    logic isSw;
    logic isBeq;
    logic isAddi;

    assign isR    = (opD == OP_RTYPE);
    assign isLw   = (opD == OP_LW);
    assign isSw   = (opD == OP_SW);
    assign isBeq  = (opD == OP_BEQ);
    assign isAddi = (opD == OP_ADDI);

    always_comb begin
        regWriteD = 1'b0;
        regDstD   = 1'b0;
        aluSrcBD  = 1'b0;
        branchD   = 1'b0;
        memWriteD = 1'b0;
        mem2RegD  = 1'b0;
        aluCtrlD  = ALU_AND;
        unique case (1'b1)
            isR: begin
                regWriteD = 1'b1;
                regDstD   = 1'b1;
                case (functD)
                    FN_ADD:  aluCtrlD = ALU_ADD;
                    FN_SUB:  aluCtrlD = ALU_SUB;
                    FN_AND:  aluCtrlD = ALU_AND;
                    FN_OR:   aluCtrlD = ALU_OR;
                    FN_SLT:  aluCtrlD = ALU_SLT;
                    // Unknown funct must not corrupt the register file.
                    default: begin
                        aluCtrlD  = ALU_AND;
                        regWriteD = 1'b0;
                    end
                endcase
            end
            isLw: begin
                regWriteD = 1'b1;
                aluSrcBD  = 1'b1;
                mem2RegD  = 1'b1;
                aluCtrlD  = ALU_ADD;
            end
            isSw: begin
                aluSrcBD  = 1'b1;
                memWriteD = 1'b1;
                aluCtrlD  = ALU_ADD;
            end
            isBeq: begin
                branchD  = 1'b1;
                aluCtrlD = ALU_SUB;
            end
            isAddi: begin
                regWriteD = 1'b1;
                aluSrcBD  = 1'b1;
                aluCtrlD  = ALU_ADD;
            end
            default: begin
                regWriteD = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic       regWriteE_q, regWriteE_d;
    logic       mem2RegE_q,  mem2RegE_d;
    logic       memWriteE_q, memWriteE_d;
    logic       regDstE_q,   regDstE_d;
    logic       aluSrcBE_q,  aluSrcBE_d;
    logic [2:0] aluCtrlE_q,  aluCtrlE_d;
    logic [4:0] writeRegE_q, writeRegE_d;

    logic       regWriteM_q;
    logic       mem2RegM_q;
    logic       memWriteM_q;
    logic [4:0] writeRegM_q;

    logic       regWriteW_q;
    logic       mem2RegW_q;
    logic [4:0] writeRegW_q;

    logic lwstall;
    logic branchstall;
    logic flushE_int;

    // A flushed Decode slot enters Execute as an all-zero bubble.
    always_comb begin
        regWriteE_d = regWriteD;
        mem2RegE_d  = mem2RegD;
        memWriteE_d = memWriteD;
        regDstE_d   = regDstD;
        aluSrcBE_d  = aluSrcBD;
        aluCtrlE_d  = aluCtrlD;
        writeRegE_d = regDstD ? rdD : rtD;
        if (flushE_int) begin
            regWriteE_d = 1'b0;
            mem2RegE_d  = 1'b0;
            memWriteE_d = 1'b0;
            regDstE_d   = 1'b0;
            aluSrcBE_d  = 1'b0;
            aluCtrlE_d  = 3'b000;
            writeRegE_d = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regWriteE_q <= 1'b0;
            mem2RegE_q  <= 1'b0;
            memWriteE_q <= 1'b0;
            regDstE_q   <= 1'b0;
            aluSrcBE_q  <= 1'b0;
            aluCtrlE_q  <= 3'b000;
            writeRegE_q <= 5'd0;
            regWriteM_q <= 1'b0;
            mem2RegM_q  <= 1'b0;
            memWriteM_q <= 1'b0;
            writeRegM_q <= 5'd0;
            regWriteW_q <= 1'b0;
            mem2RegW_q  <= 1'b0;
            writeRegW_q <= 5'd0;
        end else begin
            regWriteE_q <= regWriteE_d;
            mem2RegE_q  <= mem2RegE_d;
            memWriteE_q <= memWriteE_d;
            regDstE_q   <= regDstE_d;
            aluSrcBE_q  <= aluSrcBE_d;
            aluCtrlE_q  <= aluCtrlE_d;
            writeRegE_q <= writeRegE_d;
            regWriteM_q <= regWriteE_q;
            mem2RegM_q  <= mem2RegE_q;
            memWriteM_q <= memWriteE_q;
            writeRegM_q <= writeRegE_q;
            regWriteW_q <= regWriteM_q;
            mem2RegW_q  <= mem2RegM_q;
            writeRegW_q <= writeRegM_q;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: Memory stage has the younger value, so it wins.
    // $0 is hardwired and never forwarded.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rwM,
        input logic [4:0] wrM,
        input logic       rwW,
        input logic [4:0] wrW
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (src != 5'd0 && rwM && src == wrM) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && rwW && src == wrW) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign fad = fwd_sel(rsE, regWriteM_q, writeRegM_q,
                         regWriteW_q, writeRegW_q);
    assign fbd = fwd_sel(rtE, regWriteM_q, writeRegM_q,
                         regWriteW_q, writeRegW_q);

    // ------------------------------------------------------------------
    // Hazards
    // ------------------------------------------------------------------
    logic hitE;
    logic hitM;

    // Load-use: deliberately not qualified by $0, a load to $0 still stalls.
    assign lwstall = mem2RegE_q & ((rtE == rsD) | (rtE == rtD));

    // Branch compares in Decode: wait on an ALU result still in Execute
    // or on load data still in Memory.
    assign hitE = regWriteE_q & (writeRegE_q != 5'd0)
                & ((writeRegE_q == rsD) | (writeRegE_q == rtD));
    assign hitM = mem2RegM_q & (writeRegM_q != 5'd0)
                & ((writeRegM_q == rsD) | (writeRegM_q == rtD));
    assign branchstall = branchD & (hitE | hitM);

    assign flushE_int = lwstall | branchstall | flush;

    assign stallF = lwstall | branchstall;
    assign stallD = lwstall | branchstall;
    assign flushE = flushE_int;
    assign pcSrc  = branchD & eqD & ~branchstall;
    assign flushD = branchD & eqD & ~branchstall;

    // ------------------------------------------------------------------
    // Registered control outputs
    // ------------------------------------------------------------------
    assign regDst     = regDstE_q;
    assign aluSrcB    = aluSrcBE_q;
    assign aluControl = aluCtrlE_q;
    assign memWriteM  = memWriteM_q;
    assign regWriteW  = regWriteW_q;
    assign mem2RegW   = mem2RegW_q;

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- opD  input  6  opcode of the instruction in Decode.
- functD  input  6  funct field in Decode.
- rsD, rtD, rdD  input  5 each  register fields in Decode.
- rsE, rtE  input  5 each  source registers in Execute, supplied by the datapath ID/EX register.
- eqD  input  1  datapath Decode-stage register-equality compare result.
- flush  input  1  external Execute flush request.
- regWriteW, mem2RegW  output  1 each  Writeback-stage controls.
- memWriteM  output  1  Memory-stage store enable.
- regDst, aluSrcB  output  1 each  Execute-stage controls.
- aluControl  output  3  Execute-stage ALU operation.
- pcSrc  output  1  branch taken, combinational in Decode.
- fad, fbd  output  2 each  Execute operand A/B forward selects.
- stallF, stallD, flushE, flushD  output  1 each  hazard controls.

Function
REQ-002 Decode SHALL be combinational from opD/functD and produce regWrite, regDst, aluSrcB, branch, memWrite, mem2Reg and aluControl:
- R-type 000000: 1,1,0,0,0,0.
- lw 100011: 1,0,1,0,0,1, ALU 010.
- sw 101011: 0,x,1,0,1,0, ALU 010.
- beq 000100: 0,x,0,1,0,0, ALU 110.
- addi 001000: 1,0,1,0,0,0, ALU 010.
- Any other opcode: all controls 0, aluControl 000.
REQ-003 For R-type, funct SHALL map to aluControl as follows: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct→000 with regWrite forced to 0.
REQ-004 An ID/EX register SHALL capture regWrite, mem2Reg, memWrite, regDst, aluSrcB, aluControl and the destination register writeRegE = regDst ? rdD : rtD, each edge unless flushE=1, in which case it SHALL load all zeros.
REQ-005 An EX/MEM register SHALL capture regWrite, mem2Reg, memWrite and writeReg from ID/EX every edge.
REQ-006 A MEM/WB register SHALL capture regWrite, mem2Reg and writeReg from EX/MEM every edge.
REQ-007 Control latency SHALL be: Execute outputs 1 cycle after Decode, memWriteM 2 cycles after Decode, Writeback outputs 3 cycles after Decode.
REQ-008 fad SHALL be:
- 10 if rsE≠0, regWriteM=1 and rsE==writeRegM;
- else 01 if rsE≠0, regWriteW=1 and rsE==writeRegW;
- else 00.
Memory-stage forwarding wins when both Memory and Writeback match.
REQ-009 fbd SHALL follow the rules of REQ-008 using rtE.
REQ-010 lwstall SHALL equal mem2RegE & ((rtE==rsD) | (rtE==rtD)).
REQ-011 branchstall SHALL equal branch & ((regWriteE & writeRegE≠0 & (writeRegE==rsD | writeRegE==rtD)) | (mem2RegM & writeRegM≠0 & (writeRegM==rsD | writeRegM==rtD))).
REQ-012 stallF and stallD SHALL each equal lwstall | branchstall.
REQ-013 flushE SHALL equal lwstall | branchstall | flush.
REQ-014 pcSrc SHALL equal branch & eqD & ~branchstall.
REQ-015 flushD SHALL equal pcSrc.
REQ-016 When a stall and a taken branch occur in the same cycle, the stall SHALL win: pcSrc=0 and flushD=0.
REQ-017 Register 0 SHALL never be a forwarding or branch-hazard source; a load to $0 SHALL still raise lwstall.

Reset
REQ-018 While rst=0 at a rising edge, all ID/EX, EX/MEM and MEM/WB fields SHALL clear to 0.
REQ-019 As a result of REQ-018, the registered outputs regWriteW, mem2RegW, memWriteM, regDst, aluSrcB and aluControl SHALL be 0 after reset.
REQ-020 After reset, fad and fbd SHALL be 00, and stallF, stallD and flushE SHALL follow only their combinational Decode inputs plus flush.
REQ-021 Reset asserted mid-pipeline SHALL discard every in-flight control word in a single edge; no write or store SHALL occur in the following cycle.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- add $3,$1,$2 (op 000000, funct 100000, rd=3) → next cycle regDst=1, aluControl=010; 3 cycles after Decode regWriteW=1, mem2RegW=0.
- lw into rt=5, then add with rsD=5 in Decode → stallF=stallD=flushE=1 for one cycle; next cycle ID/EX is all zeros; one cycle later fad=01.
- add writing $4 followed immediately by sub with rsE=4 → fad=10. With the writer one instruction further back → fad=01. With rd=0 → fad=00.
- beq, eqD=1, no hazards → pcSrc=1, flushD=1. Same with the preceding instruction writing rsD → branchstall: pcSrc=0, stallD=1.
- sw → memWriteM=1 exactly 2 cycles after Decode, regWriteW=0.
- rst=0 for one edge with lw/sw/add in flight → all registered outputs 0 next cycle; memWriteM never pulses.
